// File: rtl/apb_uart_fifo_regs.sv
// APB3 register block for the UART: DATA/STATUS/CTRL/INT registers in front of TX and RX FIFOs.
// Zero wait states; PRDATA and PSLVERR are combinational during the access phase.
module apb_uart_fifo_regs #(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int ADDR_W   = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] utx_data,
    output logic              utx_valid,
    input  logic              utx_ready,
    input  logic [DATA_W-1:0] urx_data,
    input  logic              urx_valid,
    input  logic              urx_error,
    output logic              irq
);
    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int TX_CW = TX_PW + 1;
    localparam int RX_CW = RX_PW + 1;
    localparam int WI_W  = ADDR_W - 2;
    localparam logic [8:0] TX_THR_MASK = 9'((1 << TX_CW) - 1);
    localparam logic [8:0] RX_THR_MASK = 9'((1 << RX_CW) - 1);

    logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];

    logic [TX_PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [RX_PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [TX_CW-1:0] tx_count_q, tx_count_d;
    logic [RX_CW-1:0] rx_count_q, rx_count_d;
    logic             tx_en_q, tx_en_d, rx_en_q, rx_en_d;
    logic [7:0]       tx_thr_q, tx_thr_d, rx_thr_q, rx_thr_d;
    logic [5:0]       int_en_q, int_en_d;
    logic [3:0]       sticky_q, sticky_d;
    logic             irq_q, irq_d;

    logic            acc, wr, rd;
    logic [WI_W-1:0] widx;
    logic            sel_data, sel_stat, sel_ctrl, sel_inten, sel_intst, sel_level, mapped;
    logic            tx_full, tx_empty, rx_full, rx_empty;
    logic            tx_push_req, tx_push, tx_pop, tx_flush;
    logic            rx_pop_req, rx_pop, rx_push, rx_flush;
    logic            tx_low, rx_high;
    logic [5:0]      int_stat;
    logic [3:0]      sticky_set;
    logic [8:0]      tx_lvl, rx_lvl;
    logic            unused_bits;

    assign acc  = PSEL & PENABLE;
    assign wr   = acc & PWRITE;
    assign rd   = acc & ~PWRITE;
    assign widx = PADDR[ADDR_W-1:2];

    assign sel_data  = (widx == WI_W'(0));
    assign sel_stat  = (widx == WI_W'(1));
    assign sel_ctrl  = (widx == WI_W'(2));
    assign sel_inten = (widx == WI_W'(3));
    assign sel_intst = (widx == WI_W'(4));
    assign sel_level = (widx == WI_W'(5));
    assign mapped    = sel_data | sel_stat | sel_ctrl | sel_inten | sel_intst | sel_level;

    // Full/empty come from the registered counts, so same-cycle traffic never changes them.
    assign tx_full  = (tx_count_q == TX_CW'(TX_DEPTH));
    assign tx_empty = (tx_count_q == '0);
    assign rx_full  = (rx_count_q == RX_CW'(RX_DEPTH));
    assign rx_empty = (rx_count_q == '0);

    assign tx_flush    = wr & sel_ctrl & PWDATA[2];
    assign rx_flush    = wr & sel_ctrl & PWDATA[3];
    assign tx_push_req = wr & sel_data;
    assign tx_push     = tx_push_req & ~tx_full & ~tx_flush;
    assign tx_pop      = utx_valid & utx_ready & ~tx_flush;
    assign rx_pop_req  = rd & sel_data;
    assign rx_pop      = rx_pop_req & ~rx_empty & ~rx_flush;
    assign rx_push     = urx_valid & rx_en_q & ~rx_full & ~rx_flush;

    assign utx_valid = tx_en_q & ~tx_empty;
    assign utx_data  = tx_mem_q[tx_rptr_q];
    assign PREADY    = 1'b1;
    assign irq       = irq_q;

    assign tx_lvl   = 9'(tx_count_q);
    assign rx_lvl   = 9'(rx_count_q);
    assign tx_low   = (tx_lvl <= ({1'b0, tx_thr_q} & TX_THR_MASK));
    assign rx_high  = ~rx_empty & (rx_lvl >= ({1'b0, rx_thr_q} & RX_THR_MASK));
    assign int_stat = {sticky_q, rx_high, tx_low};

    assign sticky_set = {urx_error,
                         rx_pop_req & rx_empty,
                         urx_valid & rx_en_q & rx_full & ~rx_flush,
                         tx_push_req & tx_full};

    assign unused_bits = ^{PADDR[1:0], PWDATA};

    always_comb begin
        PRDATA  = 32'h0;
        PSLVERR = acc & (~mapped | (sel_data & (PWRITE ? tx_full : rx_empty)));
        if (rd) begin
            unique case (1'b1)
                sel_data:  PRDATA = rx_empty ? 32'h0 : 32'(rx_mem_q[rx_rptr_q]);
                sel_stat:  PRDATA = {28'h0, rx_full, rx_empty, tx_full, tx_empty};
                sel_ctrl:  PRDATA = {8'h00, rx_thr_q, tx_thr_q, 6'h00, rx_en_q, tx_en_q};
                sel_inten: PRDATA = {26'h0, int_en_q};
                sel_intst: PRDATA = {26'h0, int_stat};
                sel_level: PRDATA = {7'h0, rx_lvl, 7'h0, tx_lvl};
                default:   PRDATA = 32'h0;
            endcase
        end
    end

    always_comb begin
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        tx_count_d = tx_count_q;
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        rx_count_d = rx_count_q;
        tx_en_d    = tx_en_q;
        rx_en_d    = rx_en_q;
        tx_thr_d   = tx_thr_q;
        rx_thr_d   = rx_thr_q;
        int_en_d   = int_en_q;
        sticky_d   = sticky_q;

        if (tx_flush) begin
            tx_wptr_d  = '0;
            tx_rptr_d  = '0;
            tx_count_d = '0;
        end else begin
            if (tx_push) tx_wptr_d = tx_wptr_q + TX_PW'(1);
            if (tx_pop)  tx_rptr_d = tx_rptr_q + TX_PW'(1);
            if (tx_push && !tx_pop)      tx_count_d = tx_count_q + TX_CW'(1);
            else if (!tx_push && tx_pop) tx_count_d = tx_count_q - TX_CW'(1);
        end

        if (rx_flush) begin
            rx_wptr_d  = '0;
            rx_rptr_d  = '0;
            rx_count_d = '0;
        end else begin
            if (rx_push) rx_wptr_d = rx_wptr_q + RX_PW'(1);
            if (rx_pop)  rx_rptr_d = rx_rptr_q + RX_PW'(1);
            if (rx_push && !rx_pop)      rx_count_d = rx_count_q + RX_CW'(1);
            else if (!rx_push && rx_pop) rx_count_d = rx_count_q - RX_CW'(1);
        end

        if (wr && sel_ctrl) begin
            tx_en_d  = PWDATA[0];
            rx_en_d  = PWDATA[1];
            tx_thr_d = PWDATA[15:8];
            rx_thr_d = PWDATA[23:16];
        end
        if (wr && sel_inten) int_en_d = PWDATA[5:0];

        // Clear first, then OR in new events so a coincident event survives the W1C.
        if (wr && sel_intst) sticky_d = sticky_q & ~PWDATA[5:2];
        sticky_d = sticky_d | sticky_set;

        irq_d = |(int_stat & int_en_q);
    end

    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= PWDATA[DATA_W-1:0];
        if (rx_push) rx_mem_q[rx_wptr_q] <= urx_data;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_count_q <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_count_q <= '0;
            tx_en_q    <= 1'b0;
            rx_en_q    <= 1'b0;
            tx_thr_q   <= '0;
            rx_thr_q   <= '0;
            int_en_q   <= '0;
            sticky_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_count_q <= tx_count_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_count_q <= rx_count_d;
            tx_en_q    <= tx_en_d;
            rx_en_q    <= rx_en_d;
            tx_thr_q   <= tx_thr_d;
            rx_thr_q   <= rx_thr_d;
            int_en_q   <= int_en_d;
            sticky_q   <= sticky_d;
            irq_q      <= irq_d;
        end
    end
endmodule

// File: tb/tb_apb_uart_fifo_regs.sv
// Bench for apb_uart_fifo_regs: directed scenarios plus a randomized phase against a queue-based model.
module tb_apb_uart_fifo_regs;
    localparam int DATA_W   = 8;
    localparam int TX_DEPTH = 16;
    localparam int RX_DEPTH = 16;
    localparam int ADDR_W   = 8;
    localparam int DMASK    = (1 << DATA_W) - 1;

    logic              PCLK = 1'b0;
    logic              PRESETn, PSEL, PENABLE, PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA, PRDATA;
    logic              PREADY, PSLVERR;
    logic [DATA_W-1:0] utx_data, urx_data;
    logic              utx_valid, utx_ready, urx_valid, urx_error, irq;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    int tx_q[$], rx_q[$], tx_seen[$];
    int m_tx_en, m_rx_en, m_tx_thr, m_rx_thr, m_ie, m_stk;

    apb_uart_fifo_regs #(.DATA_W(DATA_W), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .ADDR_W(ADDR_W)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .utx_data(utx_data), .utx_valid(utx_valid), .utx_ready(utx_ready),
        .urx_data(urx_data), .urx_valid(urx_valid), .urx_error(urx_error), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    // Words the core accepts: handshake seen half a cycle before the edge that pops it.
    always @(negedge PCLK) begin
        if (PRESETn && utx_valid && utx_ready) tx_seen.push_back(int'(utx_data));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        tx_q.delete(); rx_q.delete(); tx_seen.delete();
        m_tx_en = 0; m_rx_en = 0; m_tx_thr = 0; m_rx_thr = 0; m_ie = 0; m_stk = 0;
    endtask

    function automatic int m_int_stat();
        int s;
        s = m_stk;
        if (tx_q.size() <= (m_tx_thr % (2 * TX_DEPTH))) s = s | 1;
        if (rx_q.size() != 0 && rx_q.size() >= (m_rx_thr % (2 * RX_DEPTH))) s = s | 2;
        return s;
    endfunction

    function automatic bit m_mapped(input int a);
        return (a & 'hFC) <= 'h14;
    endfunction

    function automatic int m_read(input int a);
        int r;
        r = 0;
        case (a & 'hFC)
            'h00: r = (rx_q.size() == 0) ? 0 : rx_q[0];
            'h04: begin
                if (tx_q.size() == 0)        r += 1;
                if (tx_q.size() == TX_DEPTH) r += 2;
                if (rx_q.size() == 0)        r += 4;
                if (rx_q.size() == RX_DEPTH) r += 8;
            end
            'h08: r = (m_rx_thr << 16) | (m_tx_thr << 8) | (m_rx_en << 1) | m_tx_en;
            'h0C: r = m_ie;
            'h10: r = m_int_stat();
            'h14: r = (rx_q.size() << 16) | tx_q.size();
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic m_rx_side(input bit sv, input bit se, input int sd, input int pre_n,
                             input int pre_en, input bit flushed);
        if (se) m_stk = m_stk | 'h20;
        if (sv && pre_en != 0 && !flushed) begin
            if (pre_n < RX_DEPTH) rx_q.push_back(sd & DMASK);
            else m_stk = m_stk | 'h08;
        end
    endtask

    // One APB transfer; optional core-side RX inputs are pulsed during the access cycle.
    task automatic bus(input bit w, input int addr, input int wdata, input bit sv, input bit se,
                       input int sd, output int rdata, output bit err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = ADDR_W'(addr); PWDATA = 32'(wdata);
        @(posedge PCLK); #1;
        PENABLE = 1'b1; urx_valid = sv; urx_error = se; urx_data = DATA_W'(sd);
        #1;
        rdata = int'(PRDATA); err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; urx_valid = 1'b0; urx_error = 1'b0;
    endtask

    task automatic bus_wr(input int addr, input int d, input bit sv = 0, input bit se = 0, input int sd = 0);
        int rdata, pre_n, pre_en, w;
        bit err, exp_err, flushed;
        w = addr & 'hFC;
        exp_err = !m_mapped(addr) || (w == 0 && tx_q.size() == TX_DEPTH);
        pre_n = rx_q.size(); pre_en = m_rx_en; flushed = 0;
        bus(1'b1, addr, d, sv, se, sd, rdata, err);
        check($sformatf("wr%02h_err", addr), 32'(err), 32'(exp_err));
        if (m_mapped(addr)) begin
            case (w)
                'h00: if (tx_q.size() == TX_DEPTH) m_stk = m_stk | 'h04; else tx_q.push_back(d & DMASK);
                'h08: begin
                    m_tx_en = d & 1; m_rx_en = (d >> 1) & 1;
                    m_tx_thr = (d >> 8) & 'hFF; m_rx_thr = (d >> 16) & 'hFF;
                    if (d & 4) tx_q.delete();
                    if (d & 8) begin rx_q.delete(); flushed = 1; end
                end
                'h0C: m_ie = d & 'h3F;
                'h10: m_stk = m_stk & ~(d & 'h3C);
                default: ;
            endcase
        end
        m_rx_side(sv, se, sd, pre_n, pre_en, flushed);
    endtask

    task automatic bus_rd(input int addr, input bit sv = 0, input bit se = 0, input int sd = 0);
        int rdata, exp_d, pre_n, pre_en;
        bit err, exp_err;
        exp_d = m_mapped(addr) ? m_read(addr) : 0;
        exp_err = !m_mapped(addr) || ((addr & 'hFC) == 0 && rx_q.size() == 0);
        pre_n = rx_q.size(); pre_en = m_rx_en;
        bus(1'b0, addr, 0, sv, se, sd, rdata, err);
        check($sformatf("rd%02h_data", addr), 32'(rdata), 32'(exp_d));
        check($sformatf("rd%02h_err", addr), 32'(err), 32'(exp_err));
        if ((addr & 'hFC) == 0) begin
            if (pre_n == 0) m_stk = m_stk | 'h10;
            else void'(rx_q.pop_front());
        end
        m_rx_side(sv, se, sd, pre_n, pre_en, 1'b0);
    endtask

    task automatic urx_pulse(input int v, input bit e);
        int pre_n;
        pre_n = rx_q.size();
        urx_valid = 1'b1; urx_error = e; urx_data = DATA_W'(v);
        @(posedge PCLK); #1;
        urx_valid = 1'b0; urx_error = 1'b0;
        m_rx_side(1'b1, e, v, pre_n, m_rx_en, 1'b0);
    endtask

    task automatic check_irq(input string tag);
        @(posedge PCLK); #1;
        check(tag, 32'(irq), 32'((m_int_stat() & m_ie) != 0));
    endtask

    // Let the core drain TX with a random ready pattern, then compare what it received in order.
    task automatic drain(input string tag);
        for (int c = 0; c < 300; c++) begin
            utx_ready = 1'($urandom_range(0, 1));
            @(posedge PCLK); #1;
            if (tx_seen.size() >= tx_q.size() && !utx_valid) break;
        end
        utx_ready = 1'b0;
        check({tag, "_cnt"}, 32'(tx_seen.size()), 32'(tx_q.size()));
        for (int i = 0; i < tx_q.size() && i < tx_seen.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 32'(tx_seen[i]), 32'(tx_q[i]));
        tx_q.delete(); tx_seen.delete();
    endtask

    task automatic read_all();
        bus_rd('h04); bus_rd('h08); bus_rd('h0C); bus_rd('h10); bus_rd('h14);
    endtask

    initial begin
        int r, c;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        utx_ready = 1'b0; urx_valid = 1'b0; urx_error = 1'b0; urx_data = '0;
        m_reset();
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_utx_valid", 32'(utx_valid), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_prdata", PRDATA, 0);
        check("rst_pslverr", 32'(PSLVERR), 0);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        read_all();
        check_irq("rst_irq2");

        // Basic TX streaming with first-word-fall-through.
        bus_wr('h08, 'h1);
        check("tx_idle_valid", 32'(utx_valid), 0);
        utx_ready = 1'b1;
        bus_wr('h00, 'h41);
        check("tx_valid_n1", 32'(utx_valid), 1);
        check("tx_head", 32'(utx_data), 'h41);
        bus_wr('h00, 'h42);
        drain("tx1");
        bus_rd('h14); bus_rd('h04);

        // TX overflow, sticky interrupt and W1C.
        bus_wr('h08, 'h0);
        for (int i = 0; i < TX_DEPTH + 1; i++) bus_wr('h00, $urandom);
        bus_rd('h14); bus_rd('h10); bus_rd('h04);
        bus_wr('h0C, 'h4);
        check_irq("irq_txovf");
        bus_wr('h10, 'h4);
        check_irq("irq_cleared");
        bus_wr('h08, 'h1);
        drain("tx16");
        bus_wr('h0C, 'h0);

        // RX threshold, ordered reads, underflow.
        bus_wr('h08, (3 << 16) | 'h2);
        urx_pulse('h11, 0); urx_pulse('h22, 0); urx_pulse('h33, 0);
        bus_rd('h10);
        for (int i = 0; i < 4; i++) bus_rd('h00);
        bus_rd('h10);

        // RX overflow and simultaneous push/pop on a half-full FIFO.
        for (int i = 0; i < RX_DEPTH + 1; i++) urx_pulse($urandom_range(0, DMASK), 0);
        bus_rd('h14); bus_rd('h10); bus_rd('h04);
        for (int i = 0; i < RX_DEPTH / 2; i++) bus_rd('h00);
        for (int i = 0; i < 4; i++) bus_rd('h00, 1, 0, $urandom_range(0, DMASK));
        bus_rd('h14);
        for (int i = 0; i < RX_DEPTH / 2 + 1; i++) bus_rd('h00);

        // Flush both FIFOs with a coincident RX push; set beats W1C.
        bus_wr('h08, 'h2);
        for (int i = 0; i < 5; i++) bus_wr('h00, $urandom);
        urx_pulse('h5A, 0); urx_pulse('hA5, 0);
        bus_rd('h14);
        bus_wr('h08, 'h0E, 1, 0, 'h77);
        bus_rd('h14);
        bus_wr('h08, 'h3);
        check("flush_utx_valid", 32'(utx_valid), 0);
        urx_pulse('h01, 1);
        bus_wr('h10, 'h20, 0, 1, 0);
        bus_rd('h10);
        bus_wr('h10, 'h3C);
        bus_rd('h10);

        // Unmapped and read-only accesses.
        bus_wr('h3C, $urandom);
        bus_rd('h3C);
        bus_wr('h04, 'hFFFF_FFFF);
        bus_wr('h14, 'hFFFF_FFFF);
        bus_rd('h04); bus_rd('h15);

        // Randomized traffic with TX disabled so the model owns the TX contents.
        bus_wr('h08, 'h2);
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 25)      bus_wr('h00, $urandom);
            else if (r < 45) bus_rd('h00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), $urandom_range(0, DMASK));
            else if (r < 70) urx_pulse($urandom_range(0, DMASK), 1'($urandom_range(0, 7) == 0));
            else if (r < 78) begin
                c = $urandom & 'h00FF_FF00;
                if ($urandom_range(0, 4) != 0) c = c | 2;
                if ($urandom_range(0, 9) == 0) c = c | 4;
                if ($urandom_range(0, 9) == 0) c = c | 8;
                bus_wr('h08, c, 1'($urandom_range(0, 1)), 0, $urandom_range(0, DMASK));
            end
            else if (r < 84) bus_wr('h0C, $urandom, 1'($urandom_range(0, 1)), 0, $urandom_range(0, DMASK));
            else if (r < 90) bus_wr('h10, $urandom, 0, 1'($urandom_range(0, 1)), 0);
            else if (r < 96) bus_rd(4 * $urandom_range(1, 5));
            else             check_irq("irq_rand");
        end
        bus_wr('h08, 'h1);
        drain("txr");

        // Asynchronous reset in the middle of a transfer.
        bus_wr('h08, 'h0);
        for (int i = 0; i < 3; i++) bus_wr('h00, $urandom);
        bus_rd('h00);
        bus_wr('h0C, 'h10);
        bus_wr('h08, 'h1);
        check_irq("irq_pre_rst");
        check("pre_rst_valid", 32'(utx_valid), 1);
        #2 PRESETn = 1'b0;
        #1;
        check("arst_utx_valid", 32'(utx_valid), 0);
        check("arst_irq", 32'(irq), 0);
        m_reset();
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(posedge PCLK); #1;
        read_all();
        bus_rd('h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
